// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-master RAM arbiter.
// Owner encoding, master indices and the lock counter width live here so the
// arbiter core and its round-robin picker agree on them.
package ram_arbiter_pkg;

  // Who currently holds the burst lock. OWN_NONE means plain round-robin.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  // Master indices as used for last-winner and read-tag bookkeeping.
  localparam logic MST_M0 = 1'b0;
  localparam logic MST_M1 = 1'b1;

  // Lock counter width; wide enough for MAX_LOCK up to 255.
  localparam int LOCK_CNT_W = 8;

  // Increment that sticks at the limit instead of wrapping.
  function automatic logic [LOCK_CNT_W-1:0] sat_inc(
    input logic [LOCK_CNT_W-1:0] value,
    input logic [LOCK_CNT_W-1:0] limit
  );
    if (value >= limit) begin
      return limit;
    end
    return value + 1'b1;
  endfunction

  // Map a master index to the owner that master would become.
  function automatic owner_t owner_of(input logic idx);
    return (idx == MST_M1) ? OWN_M1 : OWN_M0;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Combinational two-way picker: a lock owner that is still requesting wins
// outright; otherwise a lone requester wins, and on a tie the master that did
// not win last time gets the grant. Output is one-hot (or zero).
module rr_pick2
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  owner_t     owner,
  output logic [1:0] gnt
);

  // Owner priority first, then round-robin on a tie.
  always_comb begin
    gnt = 2'b00;
    if ((owner == OWN_M0) && req[0]) begin
      gnt = 2'b01;
    end else if ((owner == OWN_M1) && req[1]) begin
      gnt = 2'b10;
    end else if (req == 2'b11) begin
      gnt = (last == MST_M1) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of a single-port data RAM.
// Master 0 is the core data port, master 1 the DMA/debug loader. One access is
// granted per cycle (combinational grant), round-robin between masters, with
// an optional burst lock bounded by MAX_LOCK consecutive grants while the
// other master waits. Read data returns one cycle after the grant with a
// valid tagged to the master that issued the read.
// Optional: define RAMARB_PERF_EN to add conflict and per-master grant counters.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic [3:0]        m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic [3:0]        m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,

  output logic              mem_r,
  output logic [3:0]        mem_w,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef RAMARB_PERF_EN
  ,
  output logic [31:0]       perf_conflict,
  output logic [31:0]       perf_m0_grants,
  output logic [31:0]       perf_m1_grants
`endif
);

  localparam logic [LOCK_CNT_W-1:0] LOCK_MAX = LOCK_CNT_W'(MAX_LOCK);

  // Arbitration state
  owner_t                  owner_reg, owner_next;
  logic                    last_reg, last_next;
  logic [LOCK_CNT_W-1:0]   lock_cnt_reg, lock_cnt_next;

  // Read return pipeline
  logic                    rd_pend_reg;
  logic                    rd_tag_reg;
  logic [DATA_W-1:0]       m0_rdata_reg;
  logic [DATA_W-1:0]       m1_rdata_reg;

  // Grant and winner signals
  owner_t                  owner_eff;
  logic                    at_bound;
  logic [1:0]              pick;
  logic [1:0]              gnt;
  logic                    granted;
  logic                    win_idx;
  logic                    win_lock;
  logic [3:0]              win_we;
  logic [ADDR_W-1:0]       win_addr;
  logic [DATA_W-1:0]       win_wdata;
  logic                    win_read;

  assign at_bound = (lock_cnt_reg >= LOCK_MAX);

  // Strip the owner's priority once its lock budget is spent and the other
  // master is waiting; this forces one rotation before it can lock again.
  always_comb begin
    owner_eff = owner_reg;
    if ((owner_reg == OWN_M0) && at_bound && m1_req) begin
      owner_eff = OWN_NONE;
    end
    if ((owner_reg == OWN_M1) && at_bound && m0_req) begin
      owner_eff = OWN_NONE;
    end
  end

  rr_pick2 u_pick (
    .req   ({m1_req, m0_req}),
    .last  (last_reg),
    .owner (owner_eff),
    .gnt   (pick)
  );

  // No grant may leak out while reset is held.
  assign gnt     = rst ? 2'b00 : pick;
  assign m0_gnt  = gnt[0];
  assign m1_gnt  = gnt[1];
  assign granted = |gnt;
  assign win_idx = gnt[1];

  // Route the winning master's request fields to the RAM side.
  always_comb begin
    win_lock  = 1'b0;
    win_we    = 4'b0000;
    win_addr  = '0;
    win_wdata = '0;
    if (gnt[0]) begin
      win_lock  = m0_lock;
      win_we    = m0_we;
      win_addr  = m0_addr;
      win_wdata = m0_wdata;
    end else if (gnt[1]) begin
      win_lock  = m1_lock;
      win_we    = m1_we;
      win_addr  = m1_addr;
      win_wdata = m1_wdata;
    end
  end

  assign win_read  = granted && (win_we == 4'b0000);
  assign mem_r     = win_read;
  assign mem_w     = win_we;
  assign mem_addr  = win_addr;
  assign mem_wdata = win_wdata;

  // Owner/lock next state: a locked grant keeps or takes ownership, any other
  // outcome drops back to plain round-robin.
  always_comb begin
    owner_next    = owner_reg;
    last_next     = last_reg;
    lock_cnt_next = lock_cnt_reg;
    if (granted) begin
      last_next = win_idx;
      if (win_lock) begin
        owner_next = owner_of(win_idx);
        if (owner_reg == owner_of(win_idx)) begin
          lock_cnt_next = sat_inc(lock_cnt_reg, LOCK_MAX);
        end else begin
          lock_cnt_next = LOCK_CNT_W'(1);
        end
      end else begin
        owner_next    = OWN_NONE;
        lock_cnt_next = '0;
      end
    end else begin
      owner_next    = OWN_NONE;
      lock_cnt_next = '0;
    end
  end

  // Arbitration state register; last starts at M1 so M0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_reg    <= OWN_NONE;
      last_reg     <= MST_M1;
      lock_cnt_reg <= '0;
    end else begin
      owner_reg    <= owner_next;
      last_reg     <= last_next;
      lock_cnt_reg <= lock_cnt_next;
    end
  end

  // Remember that a read was issued and by whom, for the next-cycle return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_reg <= 1'b0;
      rd_tag_reg  <= MST_M0;
    end else begin
      rd_pend_reg <= win_read;
      if (win_read) begin
        rd_tag_reg <= win_idx;
      end
    end
  end

  assign m0_rvalid = rd_pend_reg && (rd_tag_reg == MST_M0);
  assign m1_rvalid = rd_pend_reg && (rd_tag_reg == MST_M1);

  // Hold each master's last returned word so its rdata stays put between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_rdata_reg <= '0;
      m1_rdata_reg <= '0;
    end else begin
      if (m0_rvalid) begin
        m0_rdata_reg <= mem_rdata;
      end
      if (m1_rvalid) begin
        m1_rdata_reg <= mem_rdata;
      end
    end
  end

  // RAM data passes straight through in the return cycle.
  assign m0_rdata = m0_rvalid ? mem_rdata : m0_rdata_reg;
  assign m1_rdata = m1_rvalid ? mem_rdata : m1_rdata_reg;

`ifdef RAMARB_PERF_EN
  logic [31:0] perf_conflict_reg;
  logic [31:0] perf_m0_grants_reg;
  logic [31:0] perf_m1_grants_reg;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_conflict_reg  <= '0;
      perf_m0_grants_reg <= '0;
      perf_m1_grants_reg <= '0;
    end else begin
      if (m0_req && m1_req) begin
        perf_conflict_reg <= perf_conflict_reg + 32'd1;
      end
      if (gnt[0]) begin
        perf_m0_grants_reg <= perf_m0_grants_reg + 32'd1;
      end
      if (gnt[1]) begin
        perf_m1_grants_reg <= perf_m1_grants_reg + 32'd1;
      end
    end
  end

  assign perf_conflict  = perf_conflict_reg;
  assign perf_m0_grants = perf_m0_grants_reg;
  assign perf_m1_grants = perf_m1_grants_reg;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter (MAX_LOCK=4). A behavioural RAM sits on
// the mem_* side; a shadow memory updated from the expected grants feeds a
// scoreboard of expected read returns, compared when rvalid is due.
module tb_ram_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_lock, m1_req, m1_lock;
  logic [3:0]  m0_we, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_r;
  logic [3:0]  mem_w;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef RAMARB_PERF_EN
  logic [31:0] perf_conflict, perf_m0_grants, perf_m1_grants;
`endif

  ram_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_r(mem_r), .mem_w(mem_w), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef RAMARB_PERF_EN
    ,
    .perf_conflict(perf_conflict), .perf_m0_grants(perf_m0_grants),
    .perf_m1_grants(perf_m1_grants)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] idx(input logic [31:0] a);
    return 8'(a >> 2);
  endfunction

  // Behavioural single-port RAM: registered read, byte-enabled write.
  logic [31:0] ram [0:255];
  always @(posedge clk) begin
    if (mem_r) mem_rdata <= ram[idx(mem_addr)];
    for (int b = 0; b < 4; b++) begin
      if (mem_w[b]) ram[idx(mem_addr)][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  typedef struct packed {
    logic        tag;
    logic [31:0] data;
  } rsp_t;

  rsp_t        q[$];
  logic [31:0] shadow [0:255];
  logic [31:0] exp_rd0, exp_rd1;
  int          n_tests, n_fail;

  task automatic set_m0(input logic req, input logic lock, input logic [3:0] we,
                        input logic [31:0] addr, input logic [31:0] wdata);
    m0_req = req; m0_lock = lock; m0_we = we; m0_addr = addr; m0_wdata = wdata;
  endtask

  task automatic set_m1(input logic req, input logic lock, input logic [3:0] we,
                        input logic [31:0] addr, input logic [31:0] wdata);
    m1_req = req; m1_lock = lock; m1_we = we; m1_addr = addr; m1_wdata = wdata;
  endtask

  task automatic idle_all();
    set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Bench model: apply what the expected grant does (shadow write or pushed read).
  task automatic sb_issue(input logic g0, input logic g1);
    logic        tag;
    logic [3:0]  we;
    logic [31:0] a, d;
    if (!(g0 || g1)) return;
    tag = g1;
    we  = g1 ? m1_we : m0_we;
    a   = g1 ? m1_addr : m0_addr;
    d   = g1 ? m1_wdata : m0_wdata;
    if (we == 4'h0) begin
      q.push_back('{tag: tag, data: shadow[idx(a)]});
    end else begin
      for (int b = 0; b < 4; b++) if (we[b]) shadow[idx(a)][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  // Scoreboard consumer: pop the read due this cycle (if any) and compare.
  task automatic sb_check();
    logic v0, v1;
    rsp_t e;
    v0 = 1'b0; v1 = 1'b0;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.tag) begin v1 = 1'b1; exp_rd1 = e.data; end
      else begin v0 = 1'b1; exp_rd0 = e.data; end
    end
    n_tests++;
    if (m0_rvalid !== v0) begin n_fail++; $display("FAIL sb_m0_rvalid t=%0t got %b want %b", $time, m0_rvalid, v0); end
    n_tests++;
    if (m1_rvalid !== v1) begin n_fail++; $display("FAIL sb_m1_rvalid t=%0t got %b want %b", $time, m1_rvalid, v1); end
    n_tests++;
    if (m0_rdata !== exp_rd0) begin n_fail++; $display("FAIL sb_m0_rdata t=%0t got %h want %h", $time, m0_rdata, exp_rd0); end
    n_tests++;
    if (m1_rdata !== exp_rd1) begin n_fail++; $display("FAIL sb_m1_rdata t=%0t got %h want %h", $time, m1_rdata, exp_rd1); end
  endtask

  task automatic to_drive();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    idle_all();
    @(negedge clk); sb_check();
    to_drive();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_m0(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    set_m1(1'b1, 1'b1, 4'hF, 32'h20, 32'h55);
    @(negedge clk);
    n_tests++;
    if ({m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, mem_r} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctl got %b want 00000", {m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, mem_r});
    end
    n_tests++;
    if ({mem_w, mem_addr, mem_wdata} !== 68'h0) begin
      n_fail++; $display("FAIL reset_mem got w=%h a=%h d=%h want 0", mem_w, mem_addr, mem_wdata);
    end
    n_tests++;
    if ({m0_rdata, m1_rdata} !== 64'h0) begin
      n_fail++; $display("FAIL reset_rdata got %h %h want 0", m0_rdata, m1_rdata);
    end
    to_drive();
    rst = 1'b0;
    idle_all();
    set_m0(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    @(negedge clk);
    n_tests++;
    if ({m1_gnt, m0_gnt, mem_r} !== 3'b011) begin
      n_fail++; $display("FAIL reset_read_gnt got %b want 011", {m1_gnt, m0_gnt, mem_r});
    end
    to_drive();
    rst = 1'b1;
    idle_all();
    @(negedge clk);
    n_tests++;
    if ({m1_rvalid, m0_rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL reset_midread_rvalid got %b want 00", {m1_rvalid, m0_rvalid});
    end
    to_drive();
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({m1_rvalid, m0_rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL reset_after_rvalid got %b want 00", {m1_rvalid, m0_rvalid});
    end
    q.delete();
    exp_rd0 = 32'h0;
    exp_rd1 = 32'h0;
    to_drive();
    $display("[TB] test_reset done");
  endtask

  task automatic test_single();
    set_m0(1'b1, 1'b0, 4'hF, 32'h40, 32'hDEADBEEF);
    @(negedge clk); sb_check();
    n_tests++;
    if ({m1_gnt, m0_gnt, mem_r, mem_w} !== 7'b01_0_1111 || mem_addr !== 32'h40 || mem_wdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_write got g=%b r=%b w=%h a=%h d=%h want g=01 r=0 w=f a=40 d=deadbeef",
                         {m1_gnt, m0_gnt}, mem_r, mem_w, mem_addr, mem_wdata);
    end
    sb_issue(1'b1, 1'b0);
    to_drive();
    set_m0(1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
    @(negedge clk); sb_check();
    n_tests++;
    if ({m1_gnt, m0_gnt, mem_r, mem_w} !== 7'b01_1_0000 || mem_addr !== 32'h40) begin
      n_fail++; $display("FAIL single_read got g=%b r=%b w=%h a=%h want g=01 r=1 w=0 a=40",
                         {m1_gnt, m0_gnt}, mem_r, mem_w, mem_addr);
    end
    sb_issue(1'b1, 1'b0);
    to_drive();
    idle_all();
    @(negedge clk); sb_check();
    n_tests++;
    if (m0_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_rdata got %h want deadbeef", m0_rdata);
    end
    to_drive();
    $display("[TB] test_single done");
  endtask

  task automatic test_contention();
    idle_all();
    set_m1(1'b1, 1'b0, 4'hF, 32'h44, 32'hCAFEF00D);
    @(negedge clk); sb_check(); sb_issue(1'b0, 1'b1);
    to_drive();
    for (int i = 0; i < 6; i++) begin
      logic [1:0] e;
      set_m0(1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
      set_m1(1'b1, 1'b0, 4'h0, 32'h44, 32'h0);
      e = (i % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk); sb_check();
      n_tests++;
      if ({m1_gnt, m0_gnt} !== e) begin
        n_fail++; $display("FAIL contention_gnt[%0d] got %b want %b", i, {m1_gnt, m0_gnt}, e);
      end
      sb_issue(e[0], e[1]);
      to_drive();
    end
    drain();
    $display("[TB] test_contention done");
  endtask

  task automatic test_lock_bound();
    for (int i = 0; i < 12; i++) begin
      logic r0;
      logic [1:0] e;
      r0 = ((i >= 1) && (i <= 6)) || (i == 11);
      e  = ((i == 4) || (i == 11)) ? 2'b01 : 2'b10;
      set_m0(r0, 1'b0, 4'h0, 32'h40, 32'h0);
      set_m1(1'b1, 1'b1, 4'h0, 32'h44, 32'h0);
      @(negedge clk); sb_check();
      n_tests++;
      if ({m1_gnt, m0_gnt} !== e) begin
        n_fail++; $display("FAIL lock_bound_gnt[%0d] got %b want %b", i, {m1_gnt, m0_gnt}, e);
      end
      sb_issue(e[0], e[1]);
      to_drive();
    end
    drain();
    $display("[TB] test_lock_bound done");
  endtask

  task automatic test_lock_release();
    logic [31:0] wd [0:3];
    wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333; wd[3] = 32'h44444444;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] e;
      e = (i == 3) ? 2'b10 : 2'b01;
      set_m0(1'b1, (i < 2), 4'hF, (i == 3) ? 32'h104 : 32'h100, wd[i]);
      set_m1((i >= 1), 1'b0, 4'h0, 32'h100, 32'h0);
      @(negedge clk); sb_check();
      n_tests++;
      if ({m1_gnt, m0_gnt} !== e) begin
        n_fail++; $display("FAIL lock_release_gnt[%0d] got %b want %b", i, {m1_gnt, m0_gnt}, e);
      end
      sb_issue(e[0], e[1]);
      to_drive();
    end
    drain();
    $display("[TB] test_lock_release done");
  endtask

  task automatic test_byte_write();
    idle_all();
    set_m1(1'b1, 1'b0, 4'hF, 32'h80, 32'h11223344);
    @(negedge clk); sb_check();
    n_tests++;
    if ({m1_gnt, m0_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL byte_full_gnt got %b want 10", {m1_gnt, m0_gnt});
    end
    sb_issue(1'b0, 1'b1);
    to_drive();
    set_m1(1'b1, 1'b0, 4'b0010, 32'h80, 32'h0000AB00);
    @(negedge clk); sb_check();
    n_tests++;
    if ({m1_gnt, m0_gnt, mem_w} !== 6'b10_0010) begin
      n_fail++; $display("FAIL byte_part_gnt got g=%b w=%b want g=10 w=0010", {m1_gnt, m0_gnt}, mem_w);
    end
    sb_issue(1'b0, 1'b1);
    to_drive();
    idle_all();
    set_m0(1'b1, 1'b0, 4'h0, 32'h80, 32'h0);
    @(negedge clk); sb_check();
    n_tests++;
    if ({m1_gnt, m0_gnt} !== 2'b01) begin
      n_fail++; $display("FAIL byte_read_gnt got %b want 01", {m1_gnt, m0_gnt});
    end
    sb_issue(1'b1, 1'b0);
    to_drive();
    idle_all();
    @(negedge clk); sb_check();
    n_tests++;
    if (m0_rdata !== 32'h1122AB44) begin
      n_fail++; $display("FAIL byte_rdata got %h want 1122ab44", m0_rdata);
    end
    to_drive();
    $display("[TB] test_byte_write done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_rd0 = 32'h0;
    exp_rd1 = 32'h0;
    for (int i = 0; i < 256; i++) shadow[i] = 32'h0;
    test_reset();
    test_single();
    test_contention();
    test_lock_bound();
    test_lock_release();
    test_byte_write();
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
